// File: rtl/gray_ptr_sync_decoder.sv
// gray_ptr_sync_decoder
// Brings a Gray-coded pointer from a foreign clock domain into clk through a
// plain flop synchronizer, decodes it to binary and derives the occupancy
// relative to a local binary pointer.
//
// Ports
//   clk        : clock, rising edge active
//   rst_n      : asynchronous active-low reset
//   gray_in    : [N:0] foreign Gray pointer (asynchronous to clk)
//   local_bin  : [N:0] local binary pointer (synchronous to clk)
//   err_clr    : clears the sticky overflow error
//   bin_out    : [N:0] synchronized pointer, decoded and registered
//   bin_valid  : bin_out holds a synchronized sample
//   delta      : [N:0] advance of bin_out at the last edge (modulo 2^(N+1))
//   upd        : one-cycle pulse when bin_out changed
//   level      : [N:0] (bin_out - local_bin) modulo 2^(N+1)
//   empty      : bin_out == local_bin
//   full       : level == 2^N
//   ovf_err    : sticky, level exceeded 2^N
module gray_ptr_sync_decoder #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N:0]   gray_in,
  input  logic [N:0]   local_bin,
  input  logic         err_clr,
  output logic [N:0]   bin_out,
  output logic         bin_valid,
  output logic [N:0]   delta,
  output logic         upd,
  output logic [N:0]   level,
  output logic         empty,
  output logic         full,
  output logic         ovf_err
);

  localparam int            CW       = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SYNC_STAGES);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [N:0]    HALF     = {1'b1, {N{1'b0}}};

  logic [SYNC_STAGES-1:0][N:0] sync_r;
  logic [CW-1:0]               warm_cnt_r;
  logic [N:0]                  g_s;
  logic [N:0]                  dec_s;
  logic [N:0]                  diff_s;
  logic [N:0]                  level_raw_s;
  logic                        ovf_set_s;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [N:0] gray2bin(input logic [N:0] g);
    logic [N:0] b;
    b[N] = g[N];
    for (int i = N - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign g_s = sync_r[SYNC_STAGES-1];

  // Synchronizer chain: flops only, nothing combinational in the crossing path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], gray_in};
    end
  end

  // Decode, advance and occupancy arithmetic; all modulo 2^(N+1) by width.
  always_comb begin
    dec_s       = gray2bin(g_s);
    diff_s      = dec_s - bin_out;
    level_raw_s = bin_out - local_bin;
    if (bin_valid) begin
      level     = level_raw_s;
      empty     = (bin_out == local_bin);
      full      = (level_raw_s == HALF);
      ovf_set_s = (level_raw_s > HALF);
    end else begin
      level     = {(N+1){1'b0}};
      empty     = 1'b1;
      full      = 1'b0;
      ovf_set_s = 1'b0;
    end
  end

  // Warmup counter: bin_valid rises once the first real sample reaches bin_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt_r <= '0;
      bin_valid  <= 1'b0;
    end else begin
      if (warm_cnt_r != CNT_MAX) begin
        warm_cnt_r <= warm_cnt_r + CNT_ONE;
      end else begin
        warm_cnt_r <= warm_cnt_r;
      end
      bin_valid <= bin_valid | (warm_cnt_r == CNT_MAX);
    end
  end

  // Registered pointer, advance and update pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out <= '0;
      delta   <= '0;
      upd     <= 1'b0;
    end else begin
      bin_out <= dec_s;
      delta   <= diff_s;
      // The first valid sample is a warmup artefact, not a pointer move.
      upd     <= bin_valid && (diff_s != {(N+1){1'b0}});
    end
  end

  // Sticky overflow error; a new violation wins over a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_err <= 1'b1;
    end else if (err_clr) begin
      ovf_err <= 1'b0;
    end else begin
      ovf_err <= ovf_err;
    end
  end

endmodule
